serial_tx_scheduler: RTL

Round-robin scheduler that shares the single 32-bit serial transmitter between several calculator result sources. It arbitrates among requesters, loads the winner's word into the transmitter with a sample pulse, and holds the start strobe until the transmitter reports completion. It then acknowledges the requester and releases the transmitter. A watchdog aborts transfers that never complete.

---
 rtl/serial_sched_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/serial_tx_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_sched_pkg.sv
// Shared types and constants for the serial transmitter scheduler.
package serial_sched_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StWait,
    StRelease
  } sched_state_e;

  function automatic int unsigned cnt_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int unsigned Requesters = 4,
  parameter int unsigned IdxW       = $clog2(Requesters)
) (
  input  logic [Requesters-1:0] req,
  input  logic [IdxW-1:0]       ptr,
  output logic                  valid,
  output logic [IdxW-1:0]       idx,
  output logic [Requesters-1:0] grant
);

  int unsigned pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    grant = '0;
    pos   = 0;
    for (int unsigned off = 0; off < Requesters; off++) begin
      pos = (32'(ptr) + off) % Requesters;
      if (!valid && req[pos[IdxW-1:0]]) begin
        valid = 1'b1;
        idx   = pos[IdxW-1:0];
      end
    end
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one serial transmitter among several requesters: round-robin grant, load, wait for
// completion (with watchdog), then acknowledge and release.
module serial_tx_scheduler
  import serial_sched_pkg::*;
#(
  parameter int unsigned Requesters    = 4,
  parameter int unsigned TimeoutCycles = 4096
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [Requesters-1:0]        ReqIn,
  input  logic [DATA_W*Requesters-1:0] ReqData,
  output logic [Requesters-1:0]        GrantOut,
  output logic [Requesters-1:0]        DoneOut,
  output logic                         ErrOut,
  output logic                         Busy,
  output logic [DATA_W-1:0]            TxData,
  output logic                         SampleData,
  output logic                         StartTx,
  input  logic                         TxDone,
  input  logic                         TxBusy
);

  localparam int unsigned IdxW = $clog2(Requesters);
  localparam int unsigned CntW = cnt_width(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(Requesters - 1);

  sched_state_e      state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              ok_q, ok_d;

  logic                  arb_valid;
  logic [IdxW-1:0]       arb_idx;
  logic [Requesters-1:0] arb_grant;

  rr_arbiter #(
    .Requesters(Requesters)
  ) u_arb (
    .req  (ReqIn),
    .ptr  (ptr_q),
    .valid(arb_valid),
    .idx  (arb_idx),
    .grant(arb_grant)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    ok_d      = ok_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid && !TxBusy) begin
          idx_d = arb_idx;
          for (int unsigned i = 0; i < Requesters; i++) begin
            if (arb_grant[i]) tx_data_d = ReqData[i*DATA_W +: DATA_W];
          end
          state_d = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the final watchdog cycle still counts as success.
        if (TxDone) begin
          ok_d    = 1'b1;
          state_d = StRelease;
        end else if (cnt_q == CntLast) begin
          ok_d    = 1'b0;
          state_d = StRelease;
        end
      end
      StRelease: begin
        ptr_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    GrantOut   = '0;
    DoneOut    = '0;
    ErrOut     = 1'b0;
    SampleData = 1'b0;
    StartTx    = 1'b0;
    Busy       = (state_q != StIdle);
    TxData     = tx_data_q;
    unique case (state_q)
      StLoad: begin
        SampleData      = 1'b1;
        GrantOut[idx_q] = 1'b1;
      end
      StWait: begin
        StartTx         = 1'b1;
        GrantOut[idx_q] = 1'b1;
      end
      StRelease: begin
        if (ok_q) DoneOut[idx_q] = 1'b1;
        else      ErrOut         = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tx_data_q <= '0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      ok_q      <= ok_d;
    end
  end

endmodule
